// File: rtl/alu_share_arb_pkg.sv
// alu_pkg: shared ALU opcodes, arbiter FSM states and datapath widths.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int SEL_W = 4;
  localparam int ALU_OP_MAX = 4;
  typedef enum logic [3:0] {ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4} alu_op_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, lowest index at or above ptr wins with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               any_req
);
  always_comb begin
    gnt_idx = '0;
    gnt = '0;
    any_req = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) gnt_idx = IW'((int'(ptr) + k) % NUM_REQ);
    gnt[gnt_idx] = any_req;
  end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one external ALU; define ALU_SEL_CHECK_EN
// to flag selects above the last opcode with rsp_err and bypass the ALU cycle.
module alu_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int SEL_W = alu_pkg::SEL_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic [SEL_W-1:0]           alu_sel,
  output logic [DATA_W-1:0]          alu_reg1,
  output logic [DATA_W-1:0]          alu_reg2,
  input  logic [DATA_W-1:0]          alu_out,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       busy
);
  import alu_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  arb_state_e state;
  logic [IW-1:0] rr_ptr, g, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic any_req;
  logic [SEL_W-1:0] w_sel;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .gnt(gnt), .gnt_idx(gnt_idx), .any_req(any_req)
  );
  assign w_sel = req_sel[gnt_idx*SEL_W +: SEL_W];
  // rst_n gating keeps req_ready low while reset is held, even with requests pending
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign busy = state != IDLE;
`ifndef ALU_SEL_CHECK_EN
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      g <= '0;
      alu_sel <= '0;
      alu_reg1 <= '0;
      alu_reg2 <= '0;
      rsp_data <= '0;
      rsp_valid <= '0;
`ifdef ALU_SEL_CHECK_EN
      rsp_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (any_req) begin
          g <= gnt_idx;
`ifdef ALU_SEL_CHECK_EN
          if (w_sel > SEL_W'(ALU_OP_MAX)) begin
            rsp_data <= '0;
            rsp_err <= 1'b1;
            rsp_valid <= gnt;
            state <= RESP;
          end else begin
            alu_sel <= w_sel;
            alu_reg1 <= req_a[gnt_idx*DATA_W +: DATA_W];
            alu_reg2 <= req_b[gnt_idx*DATA_W +: DATA_W];
            state <= EXEC;
          end
`else
          alu_sel <= w_sel;
          alu_reg1 <= req_a[gnt_idx*DATA_W +: DATA_W];
          alu_reg2 <= req_b[gnt_idx*DATA_W +: DATA_W];
          state <= EXEC;
`endif
        end
        EXEC: begin
          rsp_data <= alu_out;
`ifdef ALU_SEL_CHECK_EN
          rsp_err <= 1'b0;
`endif
          rsp_valid <= NUM_REQ'(1) << g;
          state <= RESP;
        end
        RESP: if (|(rsp_valid & rsp_ready)) begin
          rr_ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
          rsp_valid <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
